// File: rtl/div_mul_seq.sv
// Iterative signed multiply / restoring divide engine for MIPS mult and div.
// Operates on magnitudes over WIDTH steps, then fixes up signs and loads hi/lo.
module div_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state_r;
    logic                 op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;

    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [WIDTH:0]       mul_add_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       trial_s;
    logic [2*WIDTH-1:0]   step_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

    // Magnitudes, one iteration step, and the final sign fix-up.
    always_comb begin
        abs_a_s   = sign_a_r ? -a_r : a_r;
        abs_b_s   = sign_b_r ? -b_r : b_r;
        mul_add_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
        rem_sh_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        trial_s   = rem_sh_s - {1'b0, mcand_r};
        step_s    = acc_r;
        prod_s    = acc_r;
        fix_hi_s  = hi;
        fix_lo_s  = lo;
        if (op_r) begin
            if (!trial_s[WIDTH]) begin
                step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
            fix_hi_s = sign_a_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        end else begin
            step_s   = {mul_add_s, acc_r[WIDTH-1:1]};
            prod_s   = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            op_r     <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            mcand_r  <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        a_r      <= a;
                        b_r      <= b;
                        sign_a_r <= a[WIDTH-1];
                        sign_b_r <= b[WIDTH-1];
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_PREP;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    // Divide: quotient half holds the dividend. Multiply: low half holds the multiplier.
                    acc_r   <= {{WIDTH{1'b0}}, (op_r ? abs_a_s : abs_b_s)};
                    mcand_r <= op_r ? abs_b_s : abs_a_s;
                    cnt_r   <= {CW{1'b0}};
                    if (op_r && (b_r == {WIDTH{1'b0}})) begin
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + ONE_CNT;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_ITER;
                    end
                end
                ST_FIX: begin
                    hi      <= fix_hi_s;
                    lo      <= fix_lo_s;
                    done    <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_mul_seq.sv
// Directed self-checking bench for div_mul_seq; expected values are hand-computed.
module tb_div_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    div_mul_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation for one edge (E0); returns just after E0.
    task automatic start_op(input logic o, input logic [31:0] aa, input logic [31:0] bb);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        tick();
        start = 1'b0;
        op    = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
    endtask

    // Counts edges after E0 until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 80) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult_signed();
        int n;
        start_op(1'b0, 32'd7, 32'hFFFFFFFD);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy_rise got=%b exp=1", busy); end
        wait_done(n);
        checks++; if (n !== 34) begin failures++; $display("FAIL mult_latency got=%0d exp=34", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL mult_div_zero got=%b exp=0", div_zero); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy_at_done got=%b exp=1", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_fall got=%b exp=0", busy); end
    endtask

    task automatic test_div_and_boundaries();
        int n;
        logic [31:0] exp_hi [5];
        logic [31:0] exp_lo [5];
        logic        vop    [5];
        logic [31:0] va     [5];
        logic [31:0] vb     [5];
        vop[0] = 1'b1; va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        exp_lo[0] = 32'hFFFFFFFD; exp_hi[0] = 32'hFFFFFFFF;
        vop[1] = 1'b1; va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; exp_lo[1] = 32'h80000000; exp_hi[1] = 32'h0;
        vop[2] = 1'b0; va[2] = 32'h80000000; vb[2] = 32'h80000000; exp_lo[2] = 32'h0;        exp_hi[2] = 32'h40000000;
        vop[3] = 1'b1; va[3] = 32'd7;        vb[3] = 32'hFFFFFFFD; exp_lo[3] = 32'hFFFFFFFE; exp_hi[3] = 32'd1;
        vop[4] = 1'b1; va[4] = 32'd100;      vb[4] = 32'd7;        exp_lo[4] = 32'd14;       exp_hi[4] = 32'd2;
        for (int i = 0; i < 5; i++) begin
            start_op(vop[i], va[i], vb[i]);
            wait_done(n);
            checks++; if (n !== 34) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=34", i, n); end
            checks++; if (hi !== exp_hi[i]) begin failures++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi, exp_hi[i]); end
            checks++; if (lo !== exp_lo[i]) begin failures++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo, exp_lo[i]); end
            tick();
        end
    endtask

    // Relies on hi=2, lo=14 left by the last vector of the previous test.
    task automatic test_div_zero();
        int n;
        start_op(1'b1, 32'd5, 32'd0);
        wait_done(n);
        checks++; if (n !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", n); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL dz_hi_kept got=%h exp=2", hi); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL dz_lo_kept got=%h exp=e", lo); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy_fall got=%b exp=0", busy); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag_held got=%b exp=1", div_zero); end
    endtask

    task automatic test_busy_start_ignored();
        int n;
        int dones;
        start_op(1'b0, 32'd3, 32'd4);
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL ign_dz_cleared got=%b exp=0", div_zero); end
        n = 0;
        dones = 0;
        while (n < 80) begin
            if (n == 9) begin
                start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0; op = 1'b0; a = 32'h0; b = 32'h0;
            end
            tick();
            n++;
            if (done) begin
                dones++;
                checks++; if (n !== 34) begin failures++; $display("FAIL ign_done_edge got=%0d exp=34", n); end
                checks++; if (lo !== 32'd12) begin failures++; $display("FAIL ign_lo got=%h exp=c", lo); end
                checks++; if (hi !== 32'd0) begin failures++; $display("FAIL ign_hi got=%h exp=0", hi); end
            end
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_op();
        int n;
        start_op(1'b1, 32'd100, 32'd7);
        for (int i = 0; i < 14; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=0", lo); end
        start_op(1'b0, 32'd2, 32'd2);
        wait_done(n);
        checks++; if (n !== 34) begin failures++; $display("FAIL rst_mid_after_latency got=%0d exp=34", n); end
        checks++; if (lo !== 32'd4) begin failures++; $display("FAIL rst_mid_after_lo got=%h exp=4", lo); end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_at [$];
        int low_run;
        int max_low;
        int low_cnt;
        int n;
        start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
        low_run = 0;
        max_low = 0;
        low_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done) begin
                done_at.push_back(i);
                checks++; if (lo !== 32'd1) begin failures++; $display("FAIL b2b_lo got=%h exp=1", lo); end
            end
            if (!busy) begin
                low_cnt++;
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end else begin
                low_run = 0;
            end
        end
        start = 1'b0;
        checks++; if (done_at.size() !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_at.size()); end
        if (done_at.size() == 3) begin
            checks++; if (done_at[0] !== 34) begin failures++; $display("FAIL b2b_first got=%0d exp=34", done_at[0]); end
            checks++; if (done_at[1] - done_at[0] !== 36) begin failures++; $display("FAIL b2b_period got=%0d exp=36", done_at[1] - done_at[0]); end
            checks++; if (done_at[2] - done_at[1] !== 36) begin failures++; $display("FAIL b2b_period2 got=%0d exp=36", done_at[2] - done_at[1]); end
        end
        checks++; if (max_low !== 1) begin failures++; $display("FAIL b2b_busy_gap got=%0d exp=1", max_low); end
        checks++; if (low_cnt !== 3) begin failures++; $display("FAIL b2b_busy_low_count got=%0d exp=3", low_cnt); end
        n = 0;
        while (busy && n < 80) begin
            tick();
            n++;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        #2;
        test_reset();
        test_mult_signed();
        test_div_and_boundaries();
        test_div_zero();
        test_busy_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
